// File: rtl/zigzag_pkg.sv
// -----------------------------------------------------------------------------
// zigzag_pkg
// Shared definitions for the rail-fence (zigzag) cipher blocks.
//   - START_TOKEN_DEFAULT : default start-of-encryption token character
//   - state_t             : controller states {IDLE, ENCRYPT}
//   - *_width helpers     : derive register widths from buffer depth / max key
// -----------------------------------------------------------------------------
package zigzag_pkg;

    localparam logic [7:0] START_TOKEN_DEFAULT = 8'hFA;

    typedef enum logic {
        IDLE    = 1'b0,
        ENCRYPT = 1'b1
    } state_t;

    // pos can reach (count-1) + period, with period <= 2*max_key-2, so it has
    // to hold values up to max_chars + 2*max_key without wrapping.
    function automatic int pos_width(input int max_chars, input int max_key);
        return $clog2(max_chars + 2 * max_key + 1);
    endfunction

    // count spans 0..max_chars inclusive.
    function automatic int count_width(input int max_chars);
        return $clog2(max_chars + 1);
    endfunction

    // Rail index and latched key span 0..max_key.
    function automatic int key_width(input int max_key);
        return $clog2(max_key + 1);
    endfunction

    // Buffer address width (at least one bit).
    function automatic int index_width(input int max_chars);
        return (max_chars > 1) ? $clog2(max_chars) : 1;
    endfunction

endpackage

// File: rtl/zigzag_step_gen.sv
// -----------------------------------------------------------------------------
// zigzag_step_gen
// Combinational stride generator for walking one rail of a rail-fence cipher.
// Ports:
//   rail  in   current rail index (0..k-1)
//   phase in   0 = next hop goes down-then-up, 1 = up-then-down (middle rails)
//   k     in   rail count (1 = identity)
//   step  out  distance in characters to the next character on this rail
// -----------------------------------------------------------------------------
module zigzag_step_gen #(
    parameter int KEY_W = 4,
    parameter int POS_W = 7
) (
    input  logic [KEY_W-1:0] rail,
    input  logic             phase,
    input  logic [KEY_W-1:0] k,
    output logic [POS_W-1:0] step
);

    logic [POS_W-1:0] period;
    logic [POS_W-1:0] twice_rail;
    logic             middle;

    always_comb begin
        // A single rail degenerates to a plain sequential walk.
        if (k <= KEY_W'(1)) begin
            period = POS_W'(1);
        end else begin
            period = (POS_W'(k) << 1) - POS_W'(2);
        end
        twice_rail = POS_W'(rail) << 1;
        middle     = (rail != '0) && (rail != (k - KEY_W'(1)));

        step = period;
        if (middle) begin
            step = phase ? twice_rail : (period - twice_rail);
        end
    end

endmodule

// File: rtl/zigzag_encryption.sv
// -----------------------------------------------------------------------------
// zigzag_encryption
// Rail-fence encryptor. Collects plaintext until the start token, then emits
// the ciphertext one character per cycle, rail by rail, for the latched key.
// Each rail ends with one bubble cycle (valid_o low) where the walk runs past
// the message, so a stream lasts exactly count + K cycles.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active-high (asserted = 1)
//   data_i     in   plaintext character or start token
//   valid_i    in   data_i qualifier (ignored while busy)
//   key        in   rail count, sampled when the token is accepted
//   data_o     out  ciphertext character (holds when valid_o is low)
//   valid_o    out  data_o qualifier, one cycle per character
//   busy       out  high while streaming ciphertext
//   overflow_o out  sticky buffer-full drop flag (only with
//                   ZIGZAG_ENC_OVERFLOW_FLAG_EN defined)
//
// Build option: define ZIGZAG_ENC_OVERFLOW_FLAG_EN to add overflow_o.
// -----------------------------------------------------------------------------
module zigzag_encryption
    import zigzag_pkg::*;
#(
    parameter int                   D_WIDTH                = 8,
    parameter int                   KEY_WIDTH              = 8,
    parameter int                   MAX_NOF_CHARS          = 50,
    parameter int                   MAX_KEY                = 8,
    parameter logic [D_WIDTH-1:0]   START_ENCRYPTION_TOKEN = D_WIDTH'(START_TOKEN_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy
`ifdef ZIGZAG_ENC_OVERFLOW_FLAG_EN
    ,
    output logic                 overflow_o
`endif
);

    localparam int POS_W = pos_width(MAX_NOF_CHARS, MAX_KEY);
    localparam int CNT_W = count_width(MAX_NOF_CHARS);
    localparam int KEY_W = key_width(MAX_KEY);
    localparam int IDX_W = index_width(MAX_NOF_CHARS);

    state_t             state;
    logic [D_WIDTH-1:0] mem [MAX_NOF_CHARS];
    logic [CNT_W-1:0]   count;
    logic [POS_W-1:0]   pos;
    logic [KEY_W-1:0]   rail;
    logic [KEY_W-1:0]   k;
    logic               phase;
    logic [POS_W-1:0]   step;

    logic               is_token;
    logic               room;
    logic               in_range;
    logic               last_rail;
    logic               middle_rail;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;

    // Keys below 2 mean "no transposition"; oversized keys saturate.
    function automatic logic [KEY_W-1:0] clamp_key(input logic [KEY_WIDTH-1:0] kin);
        if (kin < KEY_WIDTH'(2)) begin
            return KEY_W'(1);
        end else if (kin > KEY_WIDTH'(MAX_KEY)) begin
            return KEY_W'(MAX_KEY);
        end else begin
            return KEY_W'(kin);
        end
    endfunction

    assign is_token    = (data_i == START_ENCRYPTION_TOKEN);
    assign room        = (count < CNT_W'(MAX_NOF_CHARS));
    assign in_range    = (pos < POS_W'(count));
    assign last_rail   = (rail == (k - KEY_W'(1)));
    assign middle_rail = (rail != '0) && !last_rail;
    assign wr_idx      = count[IDX_W-1:0];
    assign rd_idx      = pos[IDX_W-1:0];

    zigzag_step_gen #(
        .KEY_W (KEY_W),
        .POS_W (POS_W)
    ) u_step_gen (
        .rail  (rail),
        .phase (phase),
        .k     (k),
        .step  (step)
    );

    // Character buffer: data only, never reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && valid_i && !is_token && room) begin
            mem[wr_idx] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= IDLE;
            count   <= '0;
            pos     <= '0;
            rail    <= '0;
            k       <= KEY_W'(1);
            phase   <= 1'b0;
            data_o  <= '0;
            valid_o <= 1'b0;
            busy    <= 1'b0;
`ifdef ZIGZAG_ENC_OVERFLOW_FLAG_EN
            overflow_o <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    valid_o <= 1'b0;
                    if (valid_i) begin
                        if (is_token) begin
                            // An empty message never starts a stream.
                            if (count != '0) begin
                                k     <= clamp_key(key);
                                rail  <= '0;
                                pos   <= '0;
                                phase <= 1'b0;
                                busy  <= 1'b1;
                                state <= ENCRYPT;
                            end
                        end else if (room) begin
                            count <= count + CNT_W'(1);
                        end else begin
`ifdef ZIGZAG_ENC_OVERFLOW_FLAG_EN
                            overflow_o <= 1'b1;
`endif
                        end
                    end
                end

                ENCRYPT: begin
                    if (in_range) begin
                        data_o  <= mem[rd_idx];
                        valid_o <= 1'b1;
                        pos     <= pos + step;
                        if (middle_rail) begin
                            phase <= ~phase;
                        end
                    end else begin
                        // Walked past the message: one bubble, then next rail.
                        valid_o <= 1'b0;
                        if (last_rail) begin
                            busy  <= 1'b0;
                            count <= '0;
                            state <= IDLE;
`ifdef ZIGZAG_ENC_OVERFLOW_FLAG_EN
                            overflow_o <= 1'b0;
`endif
                        end else begin
                            rail  <= rail + KEY_W'(1);
                            pos   <= POS_W'(rail) + POS_W'(1);
                            phase <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
